// File: rtl/ocd_lvl_seq.sv
// OCD threshold sequencer: soft-ramps pw_par toward a clamped target, collapses it on an
// overcurrent trip, cools down and re-ramps. Optional lockout: define OCD_LVL_SEQ_LOCKOUT_EN.
module ocd_lvl_seq #(
  parameter int CLK_MHZ      = 100,
  parameter int PAR_MAX_VAL  = 255,
  parameter int RAMP_STEP_US = 10,
  parameter int COOLDOWN_US  = 1000,
  parameter int TRIP_MAX     = 3,
  localparam int W           = $clog2(PAR_MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] lvl_tgt,
  input  logic         ocd_trip,
  output logic [W-1:0] pw_par,
  output logic         fault,
  output logic         locked,
  output logic [2:0]   state
);

  localparam int STEP_RLD = CLK_MHZ * RAMP_STEP_US - 1;
  localparam int COOL_RLD = CLK_MHZ * COOLDOWN_US - 1;
  localparam int STEP_W   = (STEP_RLD > 0) ? $clog2(STEP_RLD + 1) : 1;
  localparam int COOL_W   = (COOL_RLD > 0) ? $clog2(COOL_RLD + 1) : 1;

  localparam logic [W-1:0]      PAR_MAX    = W'(PAR_MAX_VAL);
  localparam logic [STEP_W-1:0] STEP_RLD_V = STEP_W'(STEP_RLD);
  localparam logic [COOL_W-1:0] COOL_RLD_V = COOL_W'(COOL_RLD);

`ifdef OCD_LVL_SEQ_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RAMP = 3'd1,
    HOLD = 3'd2,
    TRIP = 3'd3,
    COOL = 3'd4,
    LOCK = 3'd5
  } state_t;

  state_t            st;
  logic [1:0]        trip_sync;
  logic              trip_s;
  logic [W-1:0]      tgt_c;
  logic [STEP_W-1:0] step_cnt;
  logic [COOL_W-1:0] cool_cnt;
  logic [2:0]        trip_cnt;
  logic [2:0]        trip_inc;
  logic              tick;
  logic              lock_hit;

  assign tgt_c    = (lvl_tgt > PAR_MAX) ? PAR_MAX : lvl_tgt;
  assign tick     = (step_cnt == '0);
  assign trip_inc = (trip_cnt == 3'd7) ? 3'd7 : trip_cnt + 3'd1;
  assign lock_hit = LOCK_EN && (int'(trip_inc) >= TRIP_MAX);
  assign trip_s   = trip_sync[1];
  assign state    = st;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) trip_sync <= '0;
    else     trip_sync <= {trip_sync[0], ocd_trip};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      pw_par   <= '0;
      fault    <= 1'b0;
      trip_cnt <= '0;
      step_cnt <= '0;
      cool_cnt <= '0;
    end else if (!en) begin
      st       <= IDLE;
      pw_par   <= '0;
      fault    <= 1'b0;
      trip_cnt <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          pw_par   <= '0;
          fault    <= 1'b0;
          step_cnt <= STEP_RLD_V;
          st       <= RAMP;
        end
        RAMP: begin
          if (trip_s) begin
            st     <= TRIP;
            pw_par <= '0;
            fault  <= 1'b1;
          end else if (pw_par == tgt_c) begin
            st       <= HOLD;
            trip_cnt <= '0;
          end else if (tick) begin
            // tgt_c is clamped, so a single-LSB step toward it stays in range.
            pw_par   <= (pw_par < tgt_c) ? pw_par + W'(1) : pw_par - W'(1);
            step_cnt <= STEP_RLD_V;
          end else begin
            step_cnt <= step_cnt - STEP_W'(1);
          end
        end
        HOLD: begin
          if (trip_s) begin
            st     <= TRIP;
            pw_par <= '0;
            fault  <= 1'b1;
          end else if (tgt_c != pw_par) begin
            st       <= RAMP;
            step_cnt <= STEP_RLD_V;
          end
        end
        TRIP: begin
          trip_cnt <= trip_inc;
          cool_cnt <= COOL_RLD_V;
          st       <= lock_hit ? LOCK : COOL;
        end
        COOL: begin
          if (cool_cnt != '0) begin
            cool_cnt <= cool_cnt - COOL_W'(1);
          end else if (trip_s) begin
            cool_cnt <= COOL_RLD_V;
          end else begin
            st       <= RAMP;
            pw_par   <= '0;
            fault    <= 1'b0;
            step_cnt <= STEP_RLD_V;
          end
        end
`ifdef OCD_LVL_SEQ_LOCKOUT_EN
        LOCK: begin
          pw_par <= '0;
          fault  <= 1'b1;
        end
`endif
        default: st <= IDLE;
      endcase
    end
  end

`ifdef OCD_LVL_SEQ_LOCKOUT_EN
  logic locked_q;

  // Set together with the TRIP->LOCK transition; only rst or en low releases it.
  always_ff @(posedge clk) begin
    if (rst)                       locked_q <= 1'b0;
    else if (!en)                  locked_q <= 1'b0;
    else if (st == TRIP && lock_hit) locked_q <= 1'b1;
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_ocd_lvl_seq.sv
// Directed self-checking bench for ocd_lvl_seq with small timing parameters
// (1 MHz, 2 us steps, 10 us cooldown, max 200, lockout after 3 trips).
module tb_ocd_lvl_seq;

  localparam int W = 8;
  localparam int S_IDLE = 0, S_RAMP = 1, S_HOLD = 2, S_TRIP = 3, S_COOL = 4, S_LOCK = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] lvl_tgt;
  logic         ocd_trip;
  logic [W-1:0] pw_par;
  logic         fault;
  logic         locked;
  logic [2:0]   state;

  int n_checks = 0;
  int n_fail   = 0;

  ocd_lvl_seq #(
    .CLK_MHZ     (1),
    .PAR_MAX_VAL (200),
    .RAMP_STEP_US(2),
    .COOLDOWN_US (10),
    .TRIP_MAX    (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .lvl_tgt (lvl_tgt),
    .ocd_trip(ocd_trip),
    .pw_par  (pw_par),
    .fault   (fault),
    .locked  (locked),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle trip pulse; checks TRIP at edge 3 and the state at edge 4.
  task automatic trip_pulse(input string tag, input bit expect_lock);
    ocd_trip = 1'b1;
    step();
    ocd_trip = 1'b0;
    step();
    step();
    check({tag, "_trip_state"}, state, S_TRIP);
    check({tag, "_trip_pw"}, pw_par, 0);
    check({tag, "_trip_fault"}, fault, 1);
    step();
    check({tag, "_after_state"}, state, expect_lock ? S_LOCK : S_COOL);
    check({tag, "_after_locked"}, locked, expect_lock ? 1 : 0);
    check({tag, "_after_fault"}, fault, 1);
    if (!expect_lock) begin
      for (int i = 0; i < 9; i++) step();
      check({tag, "_cool_end"}, state, S_COOL);
      step();
      check({tag, "_reramp_state"}, state, S_RAMP);
      check({tag, "_reramp_pw"}, pw_par, 0);
      check({tag, "_reramp_fault"}, fault, 0);
    end
  endtask

  // From IDLE with en low: enable and ramp to a target of 4, ending in HOLD.
  task automatic ramp_to_4(input string tag);
    lvl_tgt = 8'd4;
    en      = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check({tag, "_hold_state"}, state, S_HOLD);
    check({tag, "_hold_pw"}, pw_par, 4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  max_pw;
    bit  done;
    rst = 1'b1; en = 1'b0; lvl_tgt = '0; ocd_trip = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_pw", pw_par, 0);
    check("rst_fault", fault, 0);
    check("rst_locked", locked, 0);
    check("rst_state", state, S_IDLE);

    // 1: ramp 0..4 at two clocks per step, HOLD one cycle after reaching 4.
    en = 1'b1; lvl_tgt = 8'd4;
    step();
    check("t1_enter_state", state, S_RAMP);
    check("t1_enter_pw", pw_par, 0);
    for (int s = 1; s <= 4; s++) begin
      step();
      check($sformatf("t1_pre%0d_pw", s), pw_par, s - 1);
      step();
      check($sformatf("t1_step%0d_pw", s), pw_par, s);
      check($sformatf("t1_step%0d_state", s), state, S_RAMP);
      check($sformatf("t1_step%0d_fault", s), fault, 0);
    end
    step();
    check("t1_hold_state", state, S_HOLD);
    check("t1_hold_pw", pw_par, 4);

    // 2: lower target reverses direction.
    lvl_tgt = 8'd2;
    step();
    check("t2_enter_state", state, S_RAMP);
    check("t2_enter_pw", pw_par, 4);
    step();
    check("t2_wait1_pw", pw_par, 4);
    step();
    check("t2_step3_pw", pw_par, 3);
    step();
    check("t2_wait2_pw", pw_par, 3);
    step();
    check("t2_step2_pw", pw_par, 2);
    step();
    check("t2_hold_state", state, S_HOLD);

    // 3: out-of-range target clamps at 200.
    lvl_tgt = 8'd250;
    max_pw = 0;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      if (int'(pw_par) > max_pw) max_pw = int'(pw_par);
      if (state == 3'(S_HOLD)) done = 1'b1;
    end
    check("t3_hold_reached", done, 1);
    check("t3_pw", pw_par, 200);
    check("t3_max_pw", max_pw, 200);
    check("t3_fault", fault, 0);

    // en low forces IDLE and clears outputs.
    en = 1'b0;
    step();
    check("en_low_state", state, S_IDLE);
    check("en_low_pw", pw_par, 0);
    ramp_to_4("t4_pre");

    // 4: single-cycle trip from HOLD, cooldown, re-ramp from 0.
    ocd_trip = 1'b1;
    step();
    ocd_trip = 1'b0;
    step();
    check("t4_k1_state", state, S_HOLD);
    check("t4_k1_pw", pw_par, 4);
    step();
    check("t4_trip_state", state, S_TRIP);
    check("t4_trip_pw", pw_par, 0);
    check("t4_trip_fault", fault, 1);
    step();
    check("t4_cool_state", state, S_COOL);
    for (int i = 0; i < 9; i++) step();
    check("t4_cool_end", state, S_COOL);
    check("t4_cool_fault", fault, 1);
    step();
    check("t4_reramp_state", state, S_RAMP);
    check("t4_reramp_fault", fault, 0);
    check("t4_reramp_pw", pw_par, 0);
    step();
    step();
    check("t4_reramp_step1", pw_par, 1);
    for (int i = 0; i < 7; i++) step();
    check("t4_rehold_state", state, S_HOLD);
    check("t4_rehold_pw", pw_par, 4);

    // 5: trip held through two cooldown reloads, then released.
    ocd_trip = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      step();
      if (n == 26) ocd_trip = 1'b0;
      if (n == 3)  check("t5_trip_state", state, S_TRIP);
      if (n == 14) check("t5_reload1_state", state, S_COOL);
      if (n == 24) check("t5_reload2_state", state, S_COOL);
      if (n == 33) check("t5_last_cool_state", state, S_COOL);
      if (n == 33) check("t5_last_cool_fault", fault, 1);
      if (n == 34) check("t5_reramp_state", state, S_RAMP);
      if (n == 34) check("t5_reramp_fault", fault, 0);
    end

    // 6: three trips without reaching HOLD.
    en = 1'b0;
    step();
    en = 1'b1;
    trip_pulse("t6_a", 1'b0);
    trip_pulse("t6_b", 1'b0);
`ifdef OCD_LVL_SEQ_LOCKOUT_EN
    trip_pulse("t6_c", 1'b1);
    for (int i = 0; i < 20; i++) step();
    check("t6_lock_state", state, S_LOCK);
    check("t6_lock_pw", pw_par, 0);
    check("t6_lock_locked", locked, 1);
`else
    trip_pulse("t6_c", 1'b0);
    trip_pulse("t6_d", 1'b0);
    check("t6_nolock_locked", locked, 0);
`endif
    en = 1'b0;
    step();
    check("t6_idle_state", state, S_IDLE);
    check("t6_idle_locked", locked, 0);
    check("t6_idle_fault", fault, 0);
    ramp_to_4("t6_post");

    // 7: synchronous reset mid-ramp at pw_par=3.
    en = 1'b0;
    step();
    en = 1'b1;
    lvl_tgt = 8'd10;
    for (int i = 0; i < 7; i++) step();
    check("t7_pre_pw", pw_par, 3);
    check("t7_pre_state", state, S_RAMP);
    rst = 1'b1;
    step();
    check("t7_rst_pw", pw_par, 0);
    check("t7_rst_state", state, S_IDLE);
    check("t7_rst_fault", fault, 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
